gf180mcu_fd_sc_mcu7t5v0__rrarb3: RTL
====================================

# gf180mcu_fd_sc_mcu7t5v0__rrarb3

Three-requester round-robin arbiter with bounded grant tenure and break-before-make handover, for sharing one resource (bus driver, shared pad, multi-input gate tree) among three agents. Requests are level-sensitive, and grants are registered one-hot. ZN is the combinational NOR3 of the requests and serves as the "no requester pending" flag. The block sits between the three request sources and the shared resource's enable inputs.

## Interface
- HOLD_MAX, default 8: maximum contested cycles one owner may hold the grant. 0 means no limit.
- CNT_W, default 4: width of the tenure counter. HOLD_MAX < 2^CNT_W is required.
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- REQ1, REQ2, REQ3  input  1 each  level requests.
- GNT1, GNT2, GNT3  output  1 each  registered grants, at most one high.
- OWN  output  2  current owner: 0 = none, 1..3 = requester index. Registered.
- BUSY  output  1  registered; high when state is not IDLE.
- ZN  output  1  combinational; equals NOT(REQ1 OR REQ2 OR REQ3).

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - RELEASE: exactly one dead cycle with all GNT low.
- Pick: search for a high REQ starting at LAST+1 and wrapping 3→1. LAST is a 2-bit register holding the previous owner.
- IDLE:
  - Any REQ high at the edge → GRANT to the picked requester. CNT=0.
  - Otherwise stay in IDLE.
- GRANT, evaluated at each edge, in priority order:
  - Owner REQ low → RELEASE.
  - HOLD_MAX≠0, another REQ high, and CNT==HOLD_MAX-1 → RELEASE (preemption).
  - Otherwise stay in GRANT. CNT increments when another REQ is high and holds otherwise. CNT never resets within a tenure.
- Entering RELEASE: LAST←owner, all GNT←0, OWN←0.
- RELEASE:
  - Any REQ high → GRANT to the picked requester. CNT=0.
  - Otherwise → IDLE.
  - The previous owner is eligible in the pick, but it sits last in the search order.
- Owner drop and another request in the same cycle: RELEASE first, then grant. The handover is never made in the same cycle.
- Uncontested owner (no other REQ high) holds indefinitely, whatever HOLD_MAX is.
- Reset values: state IDLE, GNT1..3=0, OWN=0, BUSY=0, LAST=3 (REQ1 wins first), CNT=0. ZN follows its inputs during reset.
- Reset asserted mid-tenure: GNT drops immediately (asynchronously), with no RELEASE cycle.

## Timing
- Grant latency: REQ high before edge N in IDLE or RELEASE → GNT high after edge N, i.e. 1 cycle.
- Release latency: owner REQ low before edge N → GNT low after edge N.
- Handover gap: exactly 1 cycle with all GNT=0 between any two owners.
- Preempted tenure: exactly HOLD_MAX cycles with another requester waiting, then 1 RELEASE cycle.
- Worst-case wait for a continuously requesting agent: 2×(HOLD_MAX+1) cycles, provided other owners do not hold uncontested.
- GNT, OWN and BUSY change only on CLK rising edge or RST assertion. ZN is purely combinational, with no registered path.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10;
  - owner codes: NONE=0, R1=1, R2=2, R3=3;
  - the LAST reset constant (3).
- One sub-module: gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.
  - Combinational round-robin picker.
  - Inputs: 3-bit request vector and LAST. Output: 2-bit winner (0 if none).
  - Instantiated once and shared by the IDLE and RELEASE paths.
- Top level holds the state register, LAST, CNT, and the one-hot GNT decode from the next-owner value.

## Test plan
- Reset, then REQ2=1 only → GNT2=1 one cycle later, OWN=2, BUSY=1. Drop REQ2 → GNT2=0 next cycle, one RELEASE cycle, then IDLE with BUSY=0.
- REQ1, REQ2 and REQ3 all held high from reset, HOLD_MAX=8 → owners 1,2,3,1… Each tenure lasts 8 cycles, with a 1-cycle all-zero gap between tenures; at most one GNT is ever high.
- REQ3 alone held for 100 cycles, HOLD_MAX=4 → GNT3 stays high throughout. Raise REQ1 at cycle 100 → GNT3 falls after 4 more cycles, then GNT1 one cycle later.
- HOLD_MAX=0, REQ1 and REQ2 high → GNT1 is held until REQ1 drops, then RELEASE, then GNT2.
- Owner REQ1 drops in the same cycle REQ3 rises → one RELEASE cycle, then GNT3=1, OWN=3.
- Assert RST mid-tenure with GNT2=1 → GNT2, OWN and BUSY go to 0 immediately. After deassertion, with all REQ high → GNT1 is granted first.
- Throughout all scenarios: ZN equals NOR of REQ1..3 in every cycle, including while RST is high.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
// Holds the state encoding, the owner codes, the reset value of the
// last-owner register, and a helper that turns an owner code into a
// one-hot grant vector.
package gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R1   = 2'd1;
    localparam logic [1:0] OWN_R2   = 2'd2;
    localparam logic [1:0] OWN_R3   = 2'd3;

    // Starting from "requester 3 was last" makes requester 1 win first.
    localparam logic [1:0] LAST_RST = OWN_R3;

    // Owner code to grant vector {GNT3, GNT2, GNT1}; no owner gives all zero.
    function automatic logic [2:0] owner_onehot(input logic [1:0] owner);
        logic [2:0] vec;
        case (owner)
            OWN_R1:  vec = 3'b001;
            OWN_R2:  vec = 3'b010;
            OWN_R3:  vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  - request vector {REQ3, REQ2, REQ1}
//   last - owner code of the previous owner (1..3)
//   win  - owner code of the winner, 0 when no request is high
// The search starts just after the previous owner and wraps 3 -> 1, so the
// previous owner is still eligible but is considered last.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick
    import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] win
);

    always_comb begin
        win = OWN_NONE;
        case (last)
            OWN_R1: begin
                if (req[1])      win = OWN_R2;
                else if (req[2]) win = OWN_R3;
                else if (req[0]) win = OWN_R1;
            end
            OWN_R2: begin
                if (req[2])      win = OWN_R3;
                else if (req[0]) win = OWN_R1;
                else if (req[1]) win = OWN_R2;
            end
            // Code 3, and the unused code 0, both search 1, 2, 3.
            default: begin
                if (req[0])      win = OWN_R1;
                else if (req[1]) win = OWN_R2;
                else if (req[2]) win = OWN_R3;
            end
        endcase
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3.sv
// Three-requester round-robin arbiter with bounded grant tenure and a
// one-cycle break-before-make gap between owners.
// Ports:
//   CLK              - rising-edge clock
//   RST              - asynchronous active-high reset
//   REQ1..REQ3       - level-sensitive requests
//   GNT1..GNT3       - registered one-hot grants
//   OWN              - registered owner code (0 = none, 1..3)
//   BUSY             - registered, high whenever the arbiter is not idle
//   ZN               - combinational NOR of the three requests
// HOLD_MAX bounds how many contested cycles one owner keeps the grant
// (0 disables the bound); CNT_W sizes the tenure counter.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3
    import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ1,
    input  logic       REQ2,
    input  logic       REQ3,
    output logic       GNT1,
    output logic       GNT2,
    output logic       GNT3,
    output logic [1:0] OWN,
    output logic       BUSY,
    output logic       ZN
);

    localparam bit PREEMPT_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    logic [2:0]       req;
    logic [2:0]       gnt;
    logic [1:0]       last;
    logic [1:0]       pick;
    logic [CNT_W-1:0] cnt;
    logic             owner_req;
    logic             contested;
    state_t           state;

    assign req = {REQ3, REQ2, REQ1};
    assign {GNT3, GNT2, GNT1} = gnt;
    assign ZN = ~(REQ1 | REQ2 | REQ3);

    gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick u_pick (
        .req  (req),
        .last (last),
        .win  (pick)
    );

    // Whether the current owner still requests, and whether anyone else
    // is waiting. Only meaningful in GRANT, where OWN is a real owner.
    always_comb begin
        owner_req = 1'b0;
        contested = 1'b0;
        case (OWN)
            OWN_R1: begin
                owner_req = req[0];
                contested = req[1] | req[2];
            end
            OWN_R2: begin
                owner_req = req[1];
                contested = req[0] | req[2];
            end
            OWN_R3: begin
                owner_req = req[2];
                contested = req[0] | req[1];
            end
            default: begin
                owner_req = 1'b0;
                contested = 1'b0;
            end
        endcase
    end

    // Every handover passes through RELEASE, which guarantees the dead
    // cycle. The tenure counter only advances while someone else waits, so
    // an uncontested owner is never preempted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= 3'b000;
            OWN   <= OWN_NONE;
            BUSY  <= 1'b0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    if (|req) begin
                        state <= GRANT;
                        OWN   <= pick;
                        gnt   <= owner_onehot(pick);
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        OWN   <= OWN_NONE;
                        gnt   <= 3'b000;
                        BUSY  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!owner_req ||
                        (PREEMPT_EN && contested && (cnt == CNT_LIMIT))) begin
                        state <= RELEASE;
                        last  <= OWN;
                        OWN   <= OWN_NONE;
                        gnt   <= 3'b000;
                        BUSY  <= 1'b1;
                    end else if (contested) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    OWN   <= OWN_NONE;
                    gnt   <= 3'b000;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
